pipeline_controller: RTL and testbench

PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

---
 rtl/pipeline_controller.sv | 137 +++++++++++++
 tb/tb_pipeline_controller.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_controller.sv
// rtl/pipeline_controller.sv - stage hazard/branch/memory-wait/halt control for a 3-stage pipeline
module pipeline_controller #(
  parameter logic [7:0]  HALT_OPCODE = 8'hFF,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] opcode_s3,
  input  logic       hazard,
  input  logic       branch_taken,
  input  logic [7:0] branch_target,
  input  logic       mem_busy,
  input  logic       resume,
  output logic       pc_en,
  output logic       pc_load,
  output logic [7:0] pc_load_value,
  output logic       buf1_en,
  output logic       buf2_en,
  output logic       buf1_flush,
  output logic       buf2_flush,
  output logic       halted,
  output logic       timeout,
  output logic [7:0] stall_cnt
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_FLUSH    = 2'd1,
    S_WAIT_MEM = 2'd2,
    S_HALT     = 2'd3
  } state_e;

  localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [7:0] stall_cnt_q;
  logic       timeout_q, timeout_d;
  logic       stall_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      wait_cnt_q  <= 8'd0;
      stall_cnt_q <= 8'd0;
      timeout_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
      if (stall_inc && (stall_cnt_q != 8'hFF)) begin
        stall_cnt_q <= stall_cnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    stall_inc  = 1'b0;
    pc_en      = 1'b0;
    pc_load    = 1'b0;
    buf1_en    = 1'b0;
    buf2_en    = 1'b0;
    buf1_flush = 1'b0;
    buf2_flush = 1'b0;
    halted     = 1'b0;

    case (state_q)
      S_RUN, S_FLUSH: begin
        if (opcode_s3 == HALT_OPCODE) begin
          buf1_flush = 1'b1;
          buf2_flush = 1'b1;
          state_d    = S_HALT;
        end else if (branch_taken) begin
          pc_en      = 1'b1;
          pc_load    = 1'b1;
          buf1_en    = 1'b1;
          buf2_en    = 1'b1;
          buf1_flush = 1'b1;
          buf2_flush = 1'b1;
          state_d    = S_FLUSH;
        end else if (mem_busy) begin
          stall_inc  = 1'b1;
          wait_cnt_d = 8'd1;
          state_d    = S_WAIT_MEM;
        end else if (hazard && (state_q == S_RUN)) begin
          // Hold PC and stage 1, push a bubble into stage 3.
          buf2_en    = 1'b1;
          buf2_flush = 1'b1;
          stall_inc  = 1'b1;
          state_d    = S_RUN;
        end else begin
          pc_en   = 1'b1;
          buf1_en = 1'b1;
          buf2_en = 1'b1;
          state_d = S_RUN;
        end
      end

      S_WAIT_MEM: begin
        if (mem_busy) begin
          stall_inc = 1'b1;
          // Counter already holds the busy cycles seen, so this cycle exceeds the limit.
          if (wait_cnt_q >= TIMEOUT_LIM) begin
            timeout_d  = 1'b1;
            wait_cnt_d = 8'd0;
            state_d    = S_HALT;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end else begin
          pc_en      = 1'b1;
          buf1_en    = 1'b1;
          buf2_en    = 1'b1;
          wait_cnt_d = 8'd0;
          state_d    = S_RUN;
        end
      end

      S_HALT: begin
        halted = 1'b1;
        if (resume) begin
          state_d = S_RUN;
        end
      end

      default: state_d = S_RUN;
    endcase
  end

  assign pc_load_value = branch_target;
  assign timeout       = timeout_q;
  assign stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// tb/tb_pipeline_controller.sv - randomized bench for pipeline_controller against a behavioural model
module tb_pipeline_controller;

  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] opcode_s3;
  logic       hazard;
  logic       branch_taken;
  logic [7:0] branch_target;
  logic       mem_busy;
  logic       resume;
  logic       pc_en, pc_load, buf1_en, buf2_en, buf1_flush, buf2_flush, halted, timeout;
  logic [7:0] pc_load_value, stall_cnt;

  pipeline_controller #(.HALT_OPCODE(8'hFF), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .opcode_s3(opcode_s3), .hazard(hazard),
    .branch_taken(branch_taken), .branch_target(branch_target), .mem_busy(mem_busy),
    .resume(resume), .pc_en(pc_en), .pc_load(pc_load), .pc_load_value(pc_load_value),
    .buf1_en(buf1_en), .buf2_en(buf2_en), .buf1_flush(buf1_flush), .buf2_flush(buf2_flush),
    .halted(halted), .timeout(timeout), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: the pipeline is running, just redirected by a branch, waiting on memory, or stopped.
  bit running_after_branch;
  bit waiting;
  bit stopped;
  int busy_seen;
  int stalls;
  bit timed_out;

  logic [7:0] e_flags;
  bit  n_branch, n_wait, n_stop, n_stall, n_to;
  int  n_busy;

  task automatic model_reset();
    running_after_branch = 0; waiting = 0; stopped = 0;
    busy_seen = 0; stalls = 0; timed_out = 0;
  endtask

  // flags: {pc_en, pc_load, buf1_en, buf2_en, buf1_flush, buf2_flush, halted, timeout}
  task automatic model_eval();
    bit go, load, f1, f2, e1, e2, h;
    go = 0; load = 0; f1 = 0; f2 = 0; e1 = 0; e2 = 0; h = 0;
    n_branch = 0; n_wait = waiting; n_stop = stopped; n_stall = 0; n_to = 0; n_busy = busy_seen;
    if (stopped) begin
      h = 1;
      if (resume) n_stop = 0;
    end else if (waiting) begin
      if (mem_busy) begin
        n_stall = 1;
        if (busy_seen >= TO) begin n_to = 1; n_wait = 0; n_stop = 1; n_busy = 0; end
        else n_busy = busy_seen + 1;
      end else begin
        go = 1; e1 = 1; e2 = 1; n_wait = 0; n_busy = 0;
      end
    end else if (opcode_s3 == 8'hFF) begin
      f1 = 1; f2 = 1; n_stop = 1;
    end else if (branch_taken) begin
      go = 1; load = 1; e1 = 1; e2 = 1; f1 = 1; f2 = 1; n_branch = 1;
    end else if (mem_busy) begin
      n_stall = 1; n_wait = 1; n_busy = 1;
    end else if (hazard && !running_after_branch) begin
      e2 = 1; f2 = 1; n_stall = 1;
    end else begin
      go = 1; e1 = 1; e2 = 1;
    end
    e_flags = {go, load, e1, e2, f1, f2, h, timed_out};
  endtask

  task automatic model_commit();
    running_after_branch = n_branch;
    waiting = n_wait;
    stopped = n_stop;
    busy_seen = n_busy;
    if (n_stall && stalls < 255) stalls++;
    if (n_to) timed_out = 1;
  endtask

  task automatic drive(input logic [7:0] op, input bit hz, input bit br, input logic [7:0] tgt,
                       input bit mb, input bit rs);
    opcode_s3 = op; hazard = hz; branch_taken = br; branch_target = tgt; mem_busy = mb; resume = rs;
  endtask

  task automatic run_cycle(input logic [7:0] op, input bit hz, input bit br, input logic [7:0] tgt,
                           input bit mb, input bit rs);
    drive(op, hz, br, tgt, mb, rs);
    #2;
    model_eval();
    check("flags", {24'd0, pc_en, pc_load, buf1_en, buf2_en, buf1_flush, buf2_flush, halted, timeout},
          {24'd0, e_flags});
    check("pc_load_value", {24'd0, pc_load_value}, {24'd0, tgt});
    check("stall_cnt", {24'd0, stall_cnt}, stalls);
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic do_reset();
    drive(8'h00, 0, 0, 8'h00, 0, 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_stall", {24'd0, stall_cnt}, 32'd0);
    check("rst_flags", {24'd0, pc_en, pc_load, buf1_en, buf2_en, buf1_flush, buf2_flush, halted, timeout},
          32'b1011_0000);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int busy_left;

  initial begin
    rst_n = 1'b0;
    drive(8'h00, 0, 0, 8'h00, 0, 0);
    model_reset();
    #1;
    check("init_flags", {24'd0, pc_en, pc_load, buf1_en, buf2_en, buf1_flush, buf2_flush, halted, timeout},
          32'b1011_0000);
    check("init_stall", {24'd0, stall_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Three hazard cycles then normal flow
    for (int i = 0; i < 3; i++) run_cycle(8'h10, 1, 0, 8'h00, 0, 0);
    check("hazard_stall3", {24'd0, stall_cnt}, 32'd3);
    run_cycle(8'h10, 0, 0, 8'h00, 0, 0);

    // Branch to 8'h42, hazard ignored in the following flush cycle
    do_reset();
    run_cycle(8'h20, 0, 1, 8'h42, 0, 0);
    drive(8'h20, 1, 0, 8'h00, 0, 0);
    #2;
    check("flush_hazard_pc_en", {31'd0, pc_en}, 32'd1);
    run_cycle(8'h20, 1, 0, 8'h00, 0, 0);
    run_cycle(8'h20, 1, 0, 8'h00, 0, 0);

    // Memory busy for 5 cycles
    do_reset();
    for (int i = 0; i < 5; i++) run_cycle(8'h30, 0, 0, 8'h00, 1, 0);
    run_cycle(8'h30, 0, 0, 8'h00, 0, 0);
    check("mem5_stall", {24'd0, stall_cnt}, 32'd5);
    check("mem5_timeout", {31'd0, timeout}, 32'd0);

    // Memory busy for 20 cycles -> timeout and halt, resume keeps timeout
    do_reset();
    for (int i = 0; i < 20; i++) run_cycle(8'h30, 0, 0, 8'h00, 1, 0);
    check("mem20_halted", {31'd0, halted}, 32'd1);
    check("mem20_timeout", {31'd0, timeout}, 32'd1);
    run_cycle(8'h30, 0, 0, 8'h00, 0, 1);
    run_cycle(8'h30, 0, 0, 8'h00, 0, 0);
    check("resume_halted", {31'd0, halted}, 32'd0);
    check("resume_timeout", {31'd0, timeout}, 32'd1);

    // Halt opcode wins over branch; reset in HALT clears immediately
    do_reset();
    run_cycle(8'h01, 1, 0, 8'h00, 0, 0);
    drive(8'hFF, 0, 1, 8'h55, 0, 0);
    #2;
    check("halt_vs_branch_load", {31'd0, pc_load}, 32'd0);
    run_cycle(8'hFF, 0, 1, 8'h55, 0, 0);
    run_cycle(8'h00, 0, 0, 8'h00, 0, 0);
    check("halt_entered", {31'd0, halted}, 32'd1);
    do_reset();

    // Stall counter saturation
    for (int i = 0; i < 300; i++) run_cycle(8'h05, 1, 0, 8'h00, 0, 0);
    check("stall_sat", {24'd0, stall_cnt}, 32'hFF);
    run_cycle(8'h05, 1, 0, 8'h00, 0, 0);

    // Randomized traffic with memory bursts and occasional resets
    do_reset();
    busy_left = 0;
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] op;
      bit mb;
      if ($urandom_range(0, 199) == 0) do_reset();
      op = ($urandom_range(0, 99) < 4) ? 8'hFF : 8'($urandom_range(0, 254));
      if (busy_left == 0 && $urandom_range(0, 99) < 8) busy_left = $urandom_range(1, 20);
      mb = (busy_left > 0);
      if (busy_left > 0) busy_left--;
      run_cycle(op, $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 12,
                8'($urandom), mb, $urandom_range(0, 99) < 25);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
